// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, pixel types and colour helpers
package vga_pkg;

  localparam int ACTIVE_PIXEL = 640;
  localparam int ACTIVE_LINE  = 480;
  localparam int TOTAL_PIXEL  = 800;
  localparam int TOTAL_LINE   = 525;
  localparam int SCALE_SHIFT  = 2;
  localparam int FB_W         = ACTIVE_PIXEL >> SCALE_SHIFT;
  localparam int FB_H         = ACTIVE_LINE >> SCALE_SHIFT;
  localparam int ADDR_W       = 15;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

  // Bit replication so full-scale 332 codes map to full-scale 888
  function automatic rgb888_t expand332(input rgb332_t p);
    rgb888_t c;
    c.r = {p.r, p.r, p.r[2:1]};
    c.g = {p.g, p.g, p.g[2:1]};
    c.b = {p.b, p.b, p.b, p.b};
    return c;
  endfunction

  // y * k as a sum of shifted copies of y, one per set bit of the constant k
  function automatic logic [31:0] mul_const(input logic [15:0] y, input int k);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      if (k[i]) acc = acc + ({16'd0, y} << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/vga_frame_reader_if.sv
// rtl/vga_frame_reader_if.sv - back-buffer write bus between drawing engine and frame reader
interface vga_frame_reader_if #(
  parameter int ADDR_W = 15
) ();
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/fb_dpram.sv
// rtl/fb_dpram.sv - two-bank framebuffer RAM, one write port, one registered read port
module fb_dpram #(
  parameter int WORDS  = 19200,
  parameter int ADDR_W = 15
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            we_i,
  input  logic [ADDR_W:0] waddr_i,
  input  logic [7:0]      wdata_i,
  input  logic [ADDR_W:0] raddr_i,
  output logic [7:0]      rdata_o
);

  localparam int DEPTH = 2 * WORDS;

  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      rdata_q;
  logic [ADDR_W:0] w_idx;
  logic [ADDR_W:0] r_idx;
  logic            w_ok;
  logic            r_ok;

  // Bank bit is the port-address MSB; bank 1 lives directly above bank 0
  always_comb begin
    w_ok  = waddr_i[ADDR_W-1:0] < ADDR_W'(WORDS);
    r_ok  = raddr_i[ADDR_W-1:0] < ADDR_W'(WORDS);
    w_idx = (ADDR_W+1)'(waddr_i[ADDR_W-1:0]);
    r_idx = (ADDR_W+1)'(raddr_i[ADDR_W-1:0]);
    if (waddr_i[ADDR_W]) w_idx = w_idx + (ADDR_W+1)'(WORDS);
    if (raddr_i[ADDR_W]) r_idx = r_idx + (ADDR_W+1)'(WORDS);
  end

  // Storage write; contents survive reset
  always_ff @(posedge clk_i) begin
    if (we_i && w_ok) mem_q[w_idx] <= wdata_i;
  end

  // Registered read; out-of-range addresses read as black
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= r_ok ? mem_q[r_idx] : 8'd0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - double-buffered RGB332 framebuffer scan-out with sync alignment
module vga_frame_reader #(
  parameter int ACTIVE_PIXEL = 640,
  parameter int ACTIVE_LINE  = 480,
  parameter int SCALE_SHIFT  = 2,
  parameter int FB_W         = ACTIVE_PIXEL >> SCALE_SHIFT,
  parameter int FB_H         = ACTIVE_LINE >> SCALE_SHIFT,
  parameter int ADDR_W       = 15
) (
  input  logic                VGA_CLK,
  input  logic                reset_n,
  input  logic                hs_in,
  input  logic                vs_in,
  input  logic [15:0]         line_value,
  input  logic [15:0]         pixel_location,
  input  logic                visible_region,
  vga_frame_reader_if.slave   wr,
  input  logic                swap_req,
  output logic                swap_done,
  output logic                front_sel,
  output logic [15:0]         frame_count,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic [7:0]          VGA_R,
  output logic [7:0]          VGA_G,
  output logic [7:0]          VGA_B
);
  import vga_pkg::*;

  localparam int WORDS = FB_W * FB_H;

  swap_state_e     state_q, state_d;
  logic            front_q, front_d;
  logic [15:0]     count_q, count_d;
  logic            done_q, done_d;
  logic            swap_point;

  logic [15:0]     fb_x;
  logic [15:0]     fb_y;
  logic [ADDR_W-1:0] s0_addr;
  logic [ADDR_W:0] rd_addr_q;
  logic [7:0]      rd_data;
  logic [2:0]      hs_q;
  logic [2:0]      vs_q;
  logic [1:0]      vis_q;
  rgb888_t         rgb_q;
  logic            wr_fire;

  // Start of vertical blank, judged on the incoming coordinates
  assign swap_point = (line_value == 16'(ACTIVE_LINE)) && (pixel_location == 16'd0);

  // Swap FSM and its bookkeeping registers
  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SWAP_IDLE;
      front_q <= 1'b0;
      count_q <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Next state: request parks in PENDING until the swap point, extra requests ignored
  always_comb begin
    state_d = state_q;
    front_d = front_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      SWAP_IDLE: begin
        if (swap_req) state_d = SWAP_PENDING;
      end
      SWAP_PENDING: begin
        if (swap_point) begin
          state_d = SWAP_IDLE;
          front_d = ~front_q;
          count_d = count_q + 16'd1;
          done_d  = 1'b1;
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

  // Writes are held off while a swap is pending so the back buffer stays frozen
  assign wr.wr_ready = (state_q == SWAP_IDLE);
  assign wr_fire     = wr.wr_valid && wr.wr_ready && (wr.wr_addr < ADDR_W'(WORDS));

  // Down-scaled framebuffer address for the current screen coordinate
  assign fb_x    = pixel_location >> SCALE_SHIFT;
  assign fb_y    = line_value >> SCALE_SHIFT;
  assign s0_addr = ADDR_W'(mul_const(fb_y, FB_W) + {16'd0, fb_x});

  fb_dpram #(
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (VGA_CLK),
    .rst_n_i (reset_n),
    .we_i    (wr_fire),
    .waddr_i ({~front_q, wr.wr_addr}),
    .wdata_i (wr.wr_data),
    .raddr_i (rd_addr_q),
    .rdata_o (rd_data)
  );

  // Read pipeline and matching sync/visible delay lines
  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q <= '0;
      hs_q      <= '0;
      vs_q      <= '0;
      vis_q     <= '0;
      rgb_q     <= '0;
    end else begin
      rd_addr_q <= {front_q, s0_addr};
      hs_q      <= {hs_q[1:0], hs_in};
      vs_q      <= {vs_q[1:0], vs_in};
      vis_q     <= {vis_q[0], visible_region};
      rgb_q     <= vis_q[1] ? expand332(rgb332_t'(rd_data)) : '0;
    end
  end

  assign VGA_HS      = hs_q[2];
  assign VGA_VS      = vs_q[2];
  assign VGA_R       = rgb_q.r;
  assign VGA_G       = rgb_q.g;
  assign VGA_B       = rgb_q.b;
  assign swap_done   = done_q;
  assign front_sel   = front_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - directed scoreboard bench for vga_frame_reader
module tb_vga_frame_reader;
  import vga_pkg::*;

  localparam int WORDS = FB_W * FB_H;

  logic        VGA_CLK = 1'b0;
  logic        reset_n = 1'b1;
  logic        hs_in = 1'b0;
  logic        vs_in = 1'b0;
  logic        visible_region = 1'b0;
  logic        swap_req = 1'b0;
  logic [15:0] line_value = 16'd0;
  logic [15:0] pixel_location = 16'd0;
  logic        swap_done;
  logic        front_sel;
  logic [15:0] frame_count;
  logic        VGA_HS;
  logic        VGA_VS;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;

  vga_frame_reader_if #(.ADDR_W(ADDR_W)) wr ();

  vga_frame_reader dut (
    .VGA_CLK        (VGA_CLK),
    .reset_n        (reset_n),
    .hs_in          (hs_in),
    .vs_in          (vs_in),
    .line_value     (line_value),
    .pixel_location (pixel_location),
    .visible_region (visible_region),
    .wr             (wr),
    .swap_req       (swap_req),
    .swap_done      (swap_done),
    .front_sel      (front_sel),
    .frame_count    (frame_count),
    .VGA_HS         (VGA_HS),
    .VGA_VS         (VGA_VS),
    .VGA_R          (VGA_R),
    .VGA_G          (VGA_G),
    .VGA_B          (VGA_B)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  typedef struct {
    int         due;
    bit         chk_rgb;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mdl_mem [int];
  logic        mdl_front = 1'b0;
  logic        mdl_pending = 1'b0;
  logic        mdl_done = 1'b0;
  logic [15:0] mdl_count = 16'd0;
  bit          blank_ovr = 1'b0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [23:0] bench_rgb(input logic [7:0] p);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = p[7:5];
    g = p[4:2];
    b = p[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

  task automatic tick();
    exp_t e;
    int   a;
    int   key;
    e.due = cyc + 3;
    e.hs = hs_in;
    e.vs = vs_in;
    e.chk_rgb = 1'b1;
    e.r = 8'd0;
    e.g = 8'd0;
    e.b = 8'd0;
    if (visible_region) begin
      a = (int'(line_value) >> SCALE_SHIFT) * FB_W + (int'(pixel_location) >> SCALE_SHIFT);
      key = (mdl_front ? WORDS : 0) + a;
      if (mdl_mem.exists(key)) {e.r, e.g, e.b} = bench_rgb(mdl_mem[key]);
      else e.chk_rgb = 1'b0;
    end
    exp_q.push_back(e);
    if (wr.wr_valid && !mdl_pending && int'(wr.wr_addr) < WORDS)
      mdl_mem[(mdl_front ? 0 : WORDS) + int'(wr.wr_addr)] = wr.wr_data;
    mdl_done = 1'b0;
    if (!mdl_pending) begin
      if (swap_req) mdl_pending = 1'b1;
    end else if (line_value == 16'(ACTIVE_LINE) && pixel_location == 16'd0) begin
      mdl_pending = 1'b0;
      mdl_front = ~mdl_front;
      mdl_count = mdl_count + 16'd1;
      mdl_done = 1'b1;
    end
    @(posedge VGA_CLK);
    #1;
    cyc++;
    check("wr_ready", 32'(wr.wr_ready), 32'(!mdl_pending));
    check("swap_done", 32'(swap_done), 32'(mdl_done));
    check("front_sel", 32'(front_sel), 32'(mdl_front));
    check("frame_count", 32'(frame_count), 32'(mdl_count));
    while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      if (e.chk_rgb) begin
        check("VGA_R", 32'(VGA_R), 32'(e.r));
        check("VGA_G", 32'(VGA_G), 32'(e.g));
        check("VGA_B", 32'(VGA_B), 32'(e.b));
      end
      check("VGA_HS", 32'(VGA_HS), 32'(e.hs));
      check("VGA_VS", 32'(VGA_VS), 32'(e.vs));
    end
  endtask

  task automatic run(input int line, input int p0, input int n);
    for (int i = 0; i < n; i++) begin
      line_value = 16'(line);
      pixel_location = 16'(p0 + i);
      visible_region = !blank_ovr && (p0 + i < ACTIVE_PIXEL) && (line < ACTIVE_LINE);
      hs_in = (p0 + i >= 656) && (p0 + i < 752);
      vs_in = (line >= 490) && (line < 492);
      tick();
      swap_req = 1'b0;
      wr.wr_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_VGA_R", 32'(VGA_R), 32'd0);
    check("rst_VGA_G", 32'(VGA_G), 32'd0);
    check("rst_VGA_B", 32'(VGA_B), 32'd0);
    check("rst_VGA_HS", 32'(VGA_HS), 32'd0);
    check("rst_VGA_VS", 32'(VGA_VS), 32'd0);
    check("rst_front_sel", 32'(front_sel), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_swap_done", 32'(swap_done), 32'd0);
    check("rst_wr_ready", 32'(wr.wr_ready), 32'd1);
    exp_q.delete();
    mdl_front = 1'b0;
    mdl_pending = 1'b0;
    mdl_done = 1'b0;
    mdl_count = 16'd0;
    @(posedge VGA_CLK);
    #1;
    cyc++;
    reset_n = 1'b1;
  endtask

  initial begin
    wr.wr_valid = 1'b0;
    wr.wr_addr = '0;
    wr.wr_data = 8'd0;
    #2;
    do_reset();

    // Free-running blanking with an HS pulse and VS active
    run(490, 650, 12);

    // Red at fb(0,0) of bank 1, written in the same cycle as the swap request
    wr.wr_valid = 1'b1;
    wr.wr_addr = 15'd0;
    wr.wr_data = 8'hE0;
    swap_req = 1'b1;
    run(10, 700, 2);
    run(479, 796, 4);
    run(480, 0, 3);
    run(0, 0, 6);
    run(1, 0, 4);
    run(2, 0, 4);
    run(3, 0, 4);

    // 0x92 at fb(1,1) into bank 0, then swap requested at line 100
    wr.wr_valid = 1'b1;
    wr.wr_addr = 15'd161;
    wr.wr_data = 8'h92;
    run(5, 700, 1);
    swap_req = 1'b1;
    run(100, 0, 3);
    wr.wr_valid = 1'b1;
    wr.wr_addr = 15'd161;
    wr.wr_data = 8'h03;
    run(100, 5, 1);
    swap_req = 1'b1;
    run(200, 10, 2);
    run(479, 796, 4);
    run(480, 0, 3);
    for (int l = 4; l < 8; l++) run(l, 2, 8);
    run(0, 640, 2);
    blank_ovr = 1'b1;
    run(5, 4, 2);
    blank_ovr = 1'b0;

    // Request landing exactly on the swap point waits a full frame
    run(479, 797, 3);
    swap_req = 1'b1;
    run(480, 0, 3);
    run(479, 796, 4);
    run(480, 0, 3);

    // Reset mid-frame with a swap pending
    swap_req = 1'b1;
    run(150, 0, 2);
    run(200, 296, 4);
    line_value = 16'd200;
    pixel_location = 16'd300;
    visible_region = 1'b1;
    do_reset();
    wr.wr_valid = 1'b1;
    wr.wr_addr = 15'd2;
    wr.wr_data = 8'h1C;
    run(300, 700, 1);
    swap_req = 1'b1;
    run(301, 700, 1);
    run(479, 798, 2);
    run(480, 0, 2);
    run(0, 8, 4);
    run(490, 0, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
